bus_dma_master: RTL and testbench



---
 rtl/bus_dma_master_if.sv | 23 ++
 rtl/bus_dma_master.sv | 137 +++++++++++++
 tb/tb_bus_dma_master.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_dma_master_if.sv
// Master-port bundle between the DMA engine and the shared bus arbiter/slaves.
// Signal names match the arbiter's master-port naming.
interface bus_dma_master_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              M_req;
    logic              M_grant;
    logic              M_wr;
    logic [ADDR_W-1:0] M_address;
    logic [DATA_W-1:0] M_dout;
    logic [DATA_W-1:0] M_din;

    modport master (
        output M_req, M_wr, M_address, M_dout,
        input  M_grant, M_din
    );

    modport slave (
        input  M_req, M_wr, M_address, M_dout,
        output M_grant, M_din
    );
endinterface

// File: rtl/bus_dma_master.sv
// Block-copy DMA initiator: reads src+i, then writes it to dst+i for each word,
// in ascending order, and pulses done at the end. All outputs come straight from flops.
module bus_dma_master #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    bus_dma_master_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WRITE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                req_q, req_d;
    logic                wr_q, wr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        src_d   = src_q;
        dst_d   = dst_q;
        data_d  = data_q;
        addr_d  = addr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        len_d   = len;
                        cnt_d   = '0;
                        state_d = RADDR;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RADDR: begin
                if (bus.M_grant) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                data_d  = bus.M_din;
                state_d = WRITE;
            end
            WRITE: begin
                if (bus.M_grant) begin
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + LEN_W'(1);
                        state_d = RADDR;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the state register.
        req_d  = state_d inside {RADDR, RDATA, WRITE};
        busy_d = state_d inside {RADDR, RDATA, WRITE};
        wr_d   = (state_d == WRITE);
        done_d = (state_d == DONE);

        if (state_d inside {RADDR, RDATA}) begin
            addr_d = src_d + ADDR_W'(cnt_d);
        end else if (state_d == WRITE) begin
            addr_d = dst_d + ADDR_W'(cnt_d);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.M_req     = req_q;
    assign bus.M_wr      = wr_q;
    assign bus.M_address = addr_q;
    assign bus.M_dout    = data_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master: a bus-beat queue model predicts every cycle's outputs,
// and directed copies pin cycle counts and memory contents with literal values.
module tb_bus_dma_master;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;

    localparam logic [1:0] K_READ  = 2'd0;
    localparam logic [1:0] K_RDATA = 2'd1;
    localparam logic [1:0] K_WRITE = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [7:0]  addr;
        logic [31:0] data;
    } beat_t;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic [7:0] src_addr = 8'h00;
    logic [7:0] dst_addr = 8'h00;
    logic [7:0] len      = 8'h00;
    logic       busy;
    logic       done;

    bus_dma_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bus_dma_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] mem [256];
    bit          mem_init = 1'b0;
    int          wr_count = 0;
    logic [7:0]  rd_log [$];
    beat_t       exp_q [$];
    beat_t       cur;
    bit          done_exp = 1'b0;
    bit          chk_en   = 1'b0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory slave: read data appears the cycle after a granted read.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
            mem[8'h10] <= 32'h11;
            mem[8'h11] <= 32'h22;
            mem[8'h12] <= 32'h33;
            mem[8'h13] <= 32'h44;
            mem_init   <= 1'b1;
        end else if (bus.M_req && bus.M_grant) begin
            if (bus.M_wr) begin
                mem[bus.M_address] <= bus.M_dout;
                wr_count           <= wr_count + 1;
            end else begin
                bus.M_din <= mem[bus.M_address];
                if (rd_log.size() == 0 || rd_log[$] != bus.M_address)
                    rd_log.push_back(bus.M_address);
            end
        end
    end

    // Expands one copy into its bus beats, copying word by word so overlap is honoured.
    function automatic void build_beats(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
        logic [31:0] img [256];
        logic [7:0]  ra;
        logic [7:0]  wa;
        beat_t       b;
        img = mem;
        for (int i = 0; i < int'(n); i++) begin
            ra = s + 8'(i);
            wa = d + 8'(i);
            b.kind = K_READ;  b.addr = ra; b.data = 32'h0;
            exp_q.push_back(b);
            b.kind = K_RDATA;
            exp_q.push_back(b);
            b.kind = K_WRITE; b.addr = wa; b.data = img[ra];
            exp_q.push_back(b);
            img[wa] = img[ra];
        end
    endfunction

    // Model: a read/write beat retires on grant, the data beat always takes one cycle.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            done_exp <= 1'b0;
        end else if (done_exp) begin
            done_exp <= 1'b0;
        end else if (exp_q.size() != 0) begin
            if (exp_q[0].kind == K_RDATA || bus.M_grant) begin
                if (exp_q.size() == 1) done_exp <= 1'b1;
                void'(exp_q.pop_front());
            end
        end else if (start) begin
            if (len == 8'd0) done_exp <= 1'b1;
            else build_beats(src_addr, dst_addr, len);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() != 0) begin
                cur = exp_q[0];
                checkOutput("req_active", 32'(bus.M_req), 32'd1);
                checkOutput("busy_active", 32'(busy), 32'd1);
                checkOutput("done_active", 32'(done), 32'd0);
                checkOutput("wr", 32'(bus.M_wr), 32'(cur.kind == K_WRITE));
                if (cur.kind != K_RDATA)
                    checkOutput("address", 32'(bus.M_address), 32'(cur.addr));
                if (cur.kind == K_WRITE)
                    checkOutput("dout", bus.M_dout, cur.data);
            end else if (done_exp) begin
                checkOutput("done_pulse", 32'(done), 32'd1);
                checkOutput("req_in_done", 32'(bus.M_req), 32'd0);
                checkOutput("busy_in_done", 32'(busy), 32'd0);
            end else begin
                checkOutput("done_idle", 32'(done), 32'd0);
                checkOutput("req_idle", 32'(bus.M_req), 32'd0);
                checkOutput("busy_idle", 32'(busy), 32'd0);
            end
        end
    end

    // mode 0: grant held; 1: grant dropped in beat 0; 2: reset in WRITE of beat 1;
    // 3: second start with other operands while busy.
    task automatic applyStimulus(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                                 input int mode, output int cycles, output bit req_seen);
        bit done_seen = 1'b0;
        req_seen = 1'b0;
        cycles   = 0;
        @(negedge clk);
        src_addr     = s;
        dst_addr     = d;
        len          = n;
        start        = 1'b1;
        bus.M_grant  = 1'b1;
        while (cycles < 300) begin
            @(negedge clk);
            cycles++;
            start = 1'b0;
            reset = 1'b0;
            if (bus.M_req) req_seen = 1'b1;
            if (done) begin
                done_seen = 1'b1;
                if (mode != 2) break;
            end
            if (mode == 1) bus.M_grant = !(cycles inside {1, 2, 3, 6, 7});
            if (mode == 3 && cycles == 2) begin
                start    = 1'b1;
                src_addr = 8'h80;
                dst_addr = 8'h90;
                len      = 8'd2;
            end
            if (mode == 2 && cycles == 6) reset = 1'b1;
            if (mode == 2 && cycles == 7) begin
                checkOutput("t5_addr_zero", 32'(bus.M_address), 32'd0);
                checkOutput("t5_dout_zero", bus.M_dout, 32'd0);
                checkOutput("t5_wr_zero", 32'(bus.M_wr), 32'd0);
                checkOutput("t5_req_zero", 32'(bus.M_req), 32'd0);
                checkOutput("t5_busy_zero", 32'(busy), 32'd0);
            end
            if (mode == 2 && cycles == 10) break;
        end
        bus.M_grant = 1'b1;
        if (mode == 2) checkOutput("t5_no_done", 32'(done_seen), 32'd0);
        else if (!done_seen) checkOutput("done_timeout", 32'(done_seen), 32'd1);
    endtask

    initial begin
        int          cyc;
        bit          rq;
        int          w0;
        int          r0;
        logic [31:0] t1_exp [4];
        logic [7:0]  t4_rd  [4];
        logic [31:0] t4_mem [4];
        t1_exp = '{32'h11, 32'h22, 32'h33, 32'h44};
        t4_rd  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        t4_mem = '{32'hA000_00FE, 32'hA000_00FF, 32'hA000_0000, 32'hA000_0001};

        bus.M_grant = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req", 32'(bus.M_req), 32'd0);
        checkOutput("rst_wr", 32'(bus.M_wr), 32'd0);
        checkOutput("rst_addr", 32'(bus.M_address), 32'd0);
        checkOutput("rst_dout", bus.M_dout, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        chk_en = 1'b1;
        reset  = 1'b0;

        applyStimulus(8'h10, 8'h40, 8'd4, 0, cyc, rq);
        checkOutput("t1_done_cycle", 32'(cyc), 32'd13);
        for (int i = 0; i < 4; i++) checkOutput("t1_mem", mem[8'h40 + 8'(i)], t1_exp[i]);

        applyStimulus(8'h10, 8'h70, 8'd0, 0, cyc, rq);
        checkOutput("t2_done_cycle", 32'(cyc), 32'd1);
        checkOutput("t2_req_seen", 32'(rq), 32'd0);
        checkOutput("t2_mem_untouched", mem[8'h70], 32'hA000_0070);

        w0 = wr_count;
        applyStimulus(8'h10, 8'h48, 8'd4, 1, cyc, rq);
        checkOutput("t3_done_cycle", 32'(cyc), 32'd18);
        checkOutput("t3_write_count", 32'(wr_count - w0), 32'd4);
        for (int i = 0; i < 4; i++) checkOutput("t3_mem", mem[8'h48 + 8'(i)], t1_exp[i]);

        r0 = rd_log.size();
        applyStimulus(8'hFE, 8'h20, 8'd4, 0, cyc, rq);
        checkOutput("t4_done_cycle", 32'(cyc), 32'd13);
        checkOutput("t4_read_count", 32'(rd_log.size() - r0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (r0 + i < rd_log.size()) checkOutput("t4_read_addr", 32'(rd_log[r0 + i]), 32'(t4_rd[i]));
            checkOutput("t4_mem", mem[8'h20 + 8'(i)], t4_mem[i]);
        end

        applyStimulus(8'h10, 8'h58, 8'd4, 2, cyc, rq);
        checkOutput("t5_first_word", mem[8'h58], 32'h11);
        checkOutput("t5_not_reached", mem[8'h5A], 32'hA000_005A);
        applyStimulus(8'h10, 8'h50, 8'd1, 0, cyc, rq);
        checkOutput("t5_restart_cycle", 32'(cyc), 32'd4);
        checkOutput("t5_restart_mem", mem[8'h50], 32'h11);

        applyStimulus(8'h10, 8'h60, 8'd4, 3, cyc, rq);
        checkOutput("t6_done_cycle", 32'(cyc), 32'd13);
        for (int i = 0; i < 4; i++) checkOutput("t6_mem", mem[8'h60 + 8'(i)], t1_exp[i]);
        checkOutput("t6_ignored_dst", mem[8'h90], 32'hA000_0090);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
